sh_regfile: RTL and testbench

- Parametrised architectural register file for the SH-1 core and its SH-2 successor.
- Holds R0–R15 (R15 = SP), control registers SR/GBR/VBR and system registers MACH/MACL/PR.
- Provides NUM_RD combinational read ports, two GPR write ports (result and address update), a dedicated T-flag path, a 64-bit MAC path and optional write-to-read bypass.
- Adds a selectable shadow bank for R0–R7 that the single-bank SH-1 register set does not have; it sits between DECODE (reads) and WRITEBACK (writes).

---
 rtl/sh_pkg.sv | 45 ++++
 rtl/sh_gpr_bank.sv | 34 +++
 rtl/sh_regfile.sv | 168 ++++++++++++++++
 tb/tb_sh_regfile.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_pkg.sv
// Shared SH core definitions: register indices, control/system selects and SR layout.
package sh_pkg;

    localparam int unsigned GPR_AW    = 4;
    localparam int unsigned BANK_AW   = 3;
    localparam int unsigned BANK_REGS = 8;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [GPR_AW-1:0] {
        R0, R1, R2, R3, R4, R5, R6, R7,
        R8, R9, R10, R11, R12, R13, R14, R15
    } gpr_e;

    localparam gpr_e SP = R15;

    // Index 3 of each select is a hole: writes are dropped and reads return 0.
    typedef enum logic [SEL_W-1:0] {
        CTRL_SR   = 2'd0,
        CTRL_GBR  = 2'd1,
        CTRL_VBR  = 2'd2,
        CTRL_NONE = 2'd3
    } ctrl_sel_e;

    typedef enum logic [SEL_W-1:0] {
        SYS_MACH = 2'd0,
        SYS_MACL = 2'd1,
        SYS_PR   = 2'd2,
        SYS_NONE = 2'd3
    } sys_sel_e;

    typedef enum int unsigned {
        SR_T  = 0,
        SR_S  = 1,
        SR_I0 = 4,
        SR_I1 = 5,
        SR_I2 = 6,
        SR_I3 = 7,
        SR_Q  = 8,
        SR_M  = 9
    } sr_flag_e;

    localparam logic [31:0] SR_MASK_DEF  = 32'h0000_03F3;
    localparam logic [31:0] SR_RESET_DEF = 32'h0000_00F0;

endpackage

// File: rtl/sh_gpr_bank.sv
// Eight XLEN-wide registers with two write ports; wr0 overrides wr1 on the same index.
module sh_gpr_bank
    import sh_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr0_en,
    input  logic [BANK_AW-1:0]                 wr0_addr,
    input  logic [XLEN-1:0]                    wr0_data,
    input  logic                               wr1_en,
    input  logic [BANK_AW-1:0]                 wr1_addr,
    input  logic [XLEN-1:0]                    wr1_data,
    output logic [BANK_REGS-1:0][XLEN-1:0]     regs_o
);

    logic [BANK_REGS-1:0][XLEN-1:0] regs_q;
    logic [BANK_REGS-1:0][XLEN-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr1_en) regs_d[wr1_addr] = wr1_data;
        if (wr0_en) regs_d[wr0_addr] = wr0_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign regs_o = regs_q;

endmodule

// File: rtl/sh_regfile.sv
// SH-1/SH-2 architectural register file: GPRs with optional R0-R7 shadow bank,
// SR/GBR/VBR, MACH/MACL/PR, T-flag and MAC update paths.
module sh_regfile
    import sh_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned NUM_BANKS = 1,
    parameter int unsigned BYPASS    = 1,
    parameter logic [31:0] SR_MASK   = SR_MASK_DEF,
    parameter logic [31:0] SR_RESET  = SR_RESET_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][GPR_AW-1:0]  rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]    rd_data,
    input  logic                           bank_sel,
    input  logic                           wr0_en,
    input  logic [GPR_AW-1:0]              wr0_addr,
    input  logic [XLEN-1:0]                wr0_data,
    input  logic                           wr1_en,
    input  logic [GPR_AW-1:0]              wr1_addr,
    input  logic [XLEN-1:0]                wr1_data,
    input  logic                           ctrl_we,
    input  ctrl_sel_e                      ctrl_sel,
    input  logic [XLEN-1:0]                ctrl_wdata,
    output logic [XLEN-1:0]                ctrl_rdata,
    input  logic                           sys_we,
    input  sys_sel_e                       sys_sel,
    input  logic [XLEN-1:0]                sys_wdata,
    output logic [XLEN-1:0]                sys_rdata,
    input  logic                           t_we,
    input  logic                           t_d,
    input  logic                           mac_we,
    input  logic [2*XLEN-1:0]              mac_d,
    input  logic                           mac_clr,
    output logic [XLEN-1:0]                sr_q,
    output logic [XLEN-1:0]                gbr_q,
    output logic [XLEN-1:0]                vbr_q,
    output logic [XLEN-1:0]                pr_q
);

    logic [NUM_BANKS-1:0][BANK_REGS-1:0][XLEN-1:0] lo_regs;
    logic [BANK_REGS-1:0][XLEN-1:0]                hi_regs;
    logic [BANK_REGS-1:0][XLEN-1:0]                cur_lo;

    // R0-R7: one instance per bank, only the bank selected this cycle is written.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_lo
        logic hit;
        assign hit = (NUM_BANKS == 1) || (bank_sel == 1'(b));

        sh_gpr_bank #(.XLEN(XLEN)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr0_en   (wr0_en & ~wr0_addr[GPR_AW-1] & hit),
            .wr0_addr (wr0_addr[BANK_AW-1:0]),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en & ~wr1_addr[GPR_AW-1] & hit),
            .wr1_addr (wr1_addr[BANK_AW-1:0]),
            .wr1_data (wr1_data),
            .regs_o   (lo_regs[b])
        );
    end

    sh_gpr_bank #(.XLEN(XLEN)) u_hi (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en & wr0_addr[GPR_AW-1]),
        .wr0_addr (wr0_addr[BANK_AW-1:0]),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en & wr1_addr[GPR_AW-1]),
        .wr1_addr (wr1_addr[BANK_AW-1:0]),
        .wr1_data (wr1_data),
        .regs_o   (hi_regs)
    );

    if (NUM_BANKS == 2) begin : g_bank_mux
        assign cur_lo = bank_sel ? lo_regs[1] : lo_regs[0];
    end else begin : g_bank_one
        assign cur_lo = lo_regs[0];
    end

    // Read ports; bypass replays the write priority (wr0 applied last) and is off in reset.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i] = rd_addr[i][GPR_AW-1] ? hi_regs[rd_addr[i][BANK_AW-1:0]]
                                               : cur_lo[rd_addr[i][BANK_AW-1:0]];
            if ((BYPASS != 0) && !rst) begin
                if (wr1_en && (wr1_addr == rd_addr[i])) rd_data[i] = wr1_data;
                if (wr0_en && (wr0_addr == rd_addr[i])) rd_data[i] = wr0_data;
            end
        end
    end

    logic [XLEN-1:0] sr_d, gbr_d, vbr_d, pr_d;
    logic [XLEN-1:0] mach_q, macl_q, mach_d, macl_d;

    always_comb begin
        sr_d   = sr_q;
        gbr_d  = gbr_q;
        vbr_d  = vbr_q;
        pr_d   = pr_q;
        mach_d = mach_q;
        macl_d = macl_q;

        // An explicit SR write is applied after T so its T bit wins.
        if (t_we) sr_d[SR_T] = t_d;
        if (ctrl_we) begin
            case (ctrl_sel)
                CTRL_SR:  sr_d  = ctrl_wdata & XLEN'(SR_MASK);
                CTRL_GBR: gbr_d = ctrl_wdata;
                CTRL_VBR: vbr_d = ctrl_wdata;
                default:  ;
            endcase
        end

        if (mac_clr) begin
            mach_d = '0;
            macl_d = '0;
        end else if (mac_we) begin
            {mach_d, macl_d} = mac_d;
        end else if (sys_we && (sys_sel == SYS_MACH)) begin
            mach_d = sys_wdata;
        end else if (sys_we && (sys_sel == SYS_MACL)) begin
            macl_d = sys_wdata;
        end

        if (sys_we && (sys_sel == SYS_PR)) pr_d = sys_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= XLEN'(SR_RESET);
            gbr_q  <= '0;
            vbr_q  <= '0;
            pr_q   <= '0;
            mach_q <= '0;
            macl_q <= '0;
        end else begin
            sr_q   <= sr_d;
            gbr_q  <= gbr_d;
            vbr_q  <= vbr_d;
            pr_q   <= pr_d;
            mach_q <= mach_d;
            macl_q <= macl_d;
        end
    end

    always_comb begin
        case (ctrl_sel)
            CTRL_SR:  ctrl_rdata = sr_q;
            CTRL_GBR: ctrl_rdata = gbr_q;
            CTRL_VBR: ctrl_rdata = vbr_q;
            default:  ctrl_rdata = '0;
        endcase
    end

    always_comb begin
        case (sys_sel)
            SYS_MACH: sys_rdata = mach_q;
            SYS_MACL: sys_rdata = macl_q;
            SYS_PR:   sys_rdata = pr_q;
            default:  sys_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sh_regfile.sv
// Bench for sh_regfile: a banked bypassing instance and a non-bypassing twin share stimulus.
module tb_sh_regfile;
    import sh_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_RD = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_RD-1:0][3:0]      rd_addr;
    logic                        bank_sel;
    logic                        wr0_en, wr1_en;
    logic [3:0]                  wr0_addr, wr1_addr;
    logic [XLEN-1:0]             wr0_data, wr1_data;
    logic                        ctrl_we;
    ctrl_sel_e                   ctrl_sel;
    logic [XLEN-1:0]             ctrl_wdata;
    logic                        sys_we;
    sys_sel_e                    sys_sel;
    logic [XLEN-1:0]             sys_wdata;
    logic                        t_we, t_d;
    logic                        mac_we, mac_clr;
    logic [2*XLEN-1:0]           mac_d;

    logic [NUM_RD-1:0][XLEN-1:0] rd_data_a, rd_data_b;
    logic [XLEN-1:0] ctrl_rdata_a, sys_rdata_a, sr_a, gbr_a, vbr_a, pr_a;
    logic [XLEN-1:0] ctrl_rdata_b, sys_rdata_b, sr_b, gbr_b, vbr_b, pr_b;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] obs_q[$];

    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;

    sh_regfile #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_BANKS(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .bank_sel(bank_sel),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .ctrl_we(ctrl_we), .ctrl_sel(ctrl_sel), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata_a),
        .sys_we(sys_we), .sys_sel(sys_sel), .sys_wdata(sys_wdata), .sys_rdata(sys_rdata_a),
        .t_we(t_we), .t_d(t_d), .mac_we(mac_we), .mac_d(mac_d), .mac_clr(mac_clr),
        .sr_q(sr_a), .gbr_q(gbr_a), .vbr_q(vbr_a), .pr_q(pr_a)
    );

    sh_regfile #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_BANKS(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .bank_sel(bank_sel),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .ctrl_we(ctrl_we), .ctrl_sel(ctrl_sel), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata_b),
        .sys_we(sys_we), .sys_sel(sys_sel), .sys_wdata(sys_wdata), .sys_rdata(sys_rdata_b),
        .t_we(t_we), .t_d(t_d), .mac_we(mac_we), .mac_d(mac_d), .mac_clr(mac_clr),
        .sr_q(sr_b), .gbr_q(gbr_b), .vbr_q(vbr_b), .pr_q(pr_b)
    );

    task automatic clr_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        ctrl_we = 1'b0; ctrl_sel = CTRL_SR; ctrl_wdata = '0;
        sys_we = 1'b0; sys_sel = SYS_MACH; sys_wdata = '0;
        t_we = 1'b0; t_d = 1'b0;
        mac_we = 1'b0; mac_clr = 1'b0; mac_d = '0;
    endtask

    // Advance one rising edge; leave time 1 unit after it for driving and sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic test_reset();
        logic [31:0] e, o;
        string t;
        rst = 1'b1;
        clr_inputs();
        bank_sel = 1'b0;
        rd_addr = '0;
        #2;
        expect_val(32'h0, "reset_r0");       obs_q.push_back(rd_data_a[0]);
        expect_val(32'hF0, "reset_sr");      obs_q.push_back(sr_a);
        expect_val(32'h0, "reset_gbr");      obs_q.push_back(gbr_a);
        expect_val(32'h0, "reset_vbr");      obs_q.push_back(vbr_a);
        expect_val(32'h0, "reset_pr");       obs_q.push_back(pr_a);
        expect_val(32'hF0, "reset_ctrl_rd"); obs_q.push_back(ctrl_rdata_a);
        tick();
        rst = 1'b0;
        wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h1234;
        ctrl_we = 1'b1; ctrl_sel = CTRL_GBR; ctrl_wdata = 32'hFFFF_0000;
        tick();
        clr_inputs();
        rd_addr[0] = 4'd3;
        #2;
        expect_val(32'h1234, "pre_rst_r3");       obs_q.push_back(rd_data_a[0]);
        expect_val(32'hFFFF_0000, "pre_rst_gbr"); obs_q.push_back(gbr_a);
        #1;
        rst = 1'b1;
        #1;
        expect_val(32'h0, "async_rst_r3");  obs_q.push_back(rd_data_a[0]);
        expect_val(32'h0, "async_rst_gbr"); obs_q.push_back(gbr_a);
        expect_val(32'hF0, "async_rst_sr"); obs_q.push_back(sr_a);
        tick();
        rst = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] e, o;
        string t;
        bank_sel = 1'b0;
        rd_addr = '0;
        rd_addr[0] = 4'd5;
        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h0000_0BAD;
        tick();
        clr_inputs();
        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'hAAAA_5555;
        wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h0000_0004;
        #2;
        expect_val(32'hAAAA_5555, "bypass_conflict"); obs_q.push_back(rd_data_a[0]);
        expect_val(32'h0000_0BAD, "nobypass_old");    obs_q.push_back(rd_data_b[0]);
        tick();
        clr_inputs();
        expect_val(32'hAAAA_5555, "conflict_commit_a"); obs_q.push_back(rd_data_a[0]);
        expect_val(32'hAAAA_5555, "conflict_commit_b"); obs_q.push_back(rd_data_b[0]);
        wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h0000_0004;
        #1;
        expect_val(32'h0000_0004, "bypass_wr1_only"); obs_q.push_back(rd_data_a[0]);
        expect_val(32'hAAAA_5555, "nobypass_wr1_old"); obs_q.push_back(rd_data_b[0]);
        tick();
        clr_inputs();
        expect_val(32'h0000_0004, "wr1_commit"); obs_q.push_back(rd_data_b[0]);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
    endtask

    task automatic test_bank();
        logic [31:0] e, o;
        string t;
        bank_sel = 1'b0;
        wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h11;
        tick();
        bank_sel = 1'b1;
        wr0_addr = 4'd2; wr0_data = 32'h22;
        tick();
        wr0_addr = 4'd9; wr0_data = 32'h99;
        tick();
        clr_inputs();
        rd_addr = '0;
        rd_addr[0] = 4'd2;
        rd_addr[1] = 4'd9;
        bank_sel = 1'b0;
        #1;
        expect_val(32'h11, "bank0_r2"); obs_q.push_back(rd_data_a[0]);
        expect_val(32'h99, "bank0_r9"); obs_q.push_back(rd_data_a[1]);
        bank_sel = 1'b1;
        #1;
        expect_val(32'h22, "bank1_r2"); obs_q.push_back(rd_data_a[0]);
        expect_val(32'h99, "bank1_r9"); obs_q.push_back(rd_data_a[1]);
        bank_sel = 1'b0;
        #1;
        expect_val(32'h11, "bank0_again_r2"); obs_q.push_back(rd_data_a[0]);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
        tick();
    endtask

    task automatic test_sr();
        logic [31:0] e, o;
        string t;
        ctrl_we = 1'b1; ctrl_sel = CTRL_SR; ctrl_wdata = 32'hFFFF_FFFF;
        tick();
        clr_inputs();
        expect_val(32'h3F3, "sr_masked");  obs_q.push_back(sr_a);
        expect_val(32'h3F3, "sr_ctrl_rd"); obs_q.push_back(ctrl_rdata_a);
        t_we = 1'b1; t_d = 1'b0;
        tick();
        clr_inputs();
        expect_val(32'h3F2, "t_clear"); obs_q.push_back(sr_a);
        ctrl_we = 1'b1; ctrl_sel = CTRL_SR; ctrl_wdata = 32'h001;
        t_we = 1'b1; t_d = 1'b0;
        tick();
        clr_inputs();
        expect_val(32'h001, "sr_over_t"); obs_q.push_back(sr_a);
        ctrl_we = 1'b1; ctrl_sel = CTRL_GBR; ctrl_wdata = 32'h55;
        t_we = 1'b1; t_d = 1'b0;
        tick();
        clr_inputs();
        expect_val(32'h000, "t_with_gbr_write"); obs_q.push_back(sr_a);
        expect_val(32'h55, "gbr_write");         obs_q.push_back(gbr_a);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
    endtask

    task automatic test_mac();
        logic [31:0] e, o;
        string t;
        mac_we = 1'b1; mac_d = 64'h0123_4567_89AB_CDEF;
        tick();
        clr_inputs();
        sys_sel = SYS_MACH;
        #1;
        expect_val(32'h0123_4567, "mach_load"); obs_q.push_back(sys_rdata_a);
        sys_sel = SYS_MACL;
        #1;
        expect_val(32'h89AB_CDEF, "macl_load"); obs_q.push_back(sys_rdata_a);
        mac_clr = 1'b1;
        sys_we = 1'b1; sys_sel = SYS_MACL; sys_wdata = 32'h5;
        tick();
        clr_inputs();
        sys_sel = SYS_MACH;
        #1;
        expect_val(32'h0, "clr_mach"); obs_q.push_back(sys_rdata_a);
        sys_sel = SYS_MACL;
        #1;
        expect_val(32'h0, "clr_macl"); obs_q.push_back(sys_rdata_a);
        mac_we = 1'b1; mac_d = 64'h1111_2222_3333_4444;
        sys_we = 1'b1; sys_sel = SYS_MACH; sys_wdata = 32'h0000_FFFF;
        tick();
        clr_inputs();
        sys_sel = SYS_MACH;
        #1;
        expect_val(32'h1111_2222, "mac_over_sys"); obs_q.push_back(sys_rdata_a);
        mac_clr = 1'b1;
        sys_we = 1'b1; sys_sel = SYS_PR; sys_wdata = 32'h77;
        tick();
        clr_inputs();
        sys_sel = SYS_PR;
        #1;
        expect_val(32'h77, "pr_sys_rd"); obs_q.push_back(sys_rdata_a);
        expect_val(32'h77, "pr_q");      obs_q.push_back(pr_a);
        sys_sel = SYS_NONE;
        #1;
        expect_val(32'h0, "sys_sel3_rd"); obs_q.push_back(sys_rdata_a);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
        tick();
    endtask

    task automatic test_invalid();
        logic [31:0] e, o;
        string t;
        ctrl_we = 1'b1; ctrl_sel = CTRL_SR; ctrl_wdata = 32'h0000_0082;
        tick();
        ctrl_sel = CTRL_VBR; ctrl_wdata = 32'h100;
        tick();
        ctrl_sel = CTRL_NONE; ctrl_wdata = 32'hDEAD;
        tick();
        clr_inputs();
        ctrl_sel = CTRL_NONE;
        #1;
        expect_val(32'h082, "inv_sr");      obs_q.push_back(sr_a);
        expect_val(32'h55, "inv_gbr");      obs_q.push_back(gbr_a);
        expect_val(32'h100, "inv_vbr");     obs_q.push_back(vbr_a);
        expect_val(32'h0, "inv_ctrl_rd");   obs_q.push_back(ctrl_rdata_a);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, o, base;
        string t;
        int bk;
        rst = 1'b1;
        clr_inputs();
        tick();
        rst = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++) mdl[b][r] = '0;
        for (int c = 0; c < 24; c++) begin
            bank_sel = 1'($urandom_range(0, 1));
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_addr = 4'($urandom_range(0, 15));
            wr0_data = $urandom;
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_addr = (c % 4 == 0) ? wr0_addr : 4'($urandom_range(0, 15));
            wr1_data = $urandom;
            for (int p = 0; p < NUM_RD; p++)
                rd_addr[p] = (p == 0) ? wr0_addr : 4'($urandom_range(0, 15));
            bk = bank_sel ? 1 : 0;
            for (int p = 0; p < NUM_RD; p++) begin
                base = rd_addr[p][3] ? mdl[0][rd_addr[p]] : mdl[bk][rd_addr[p]];
                e = base;
                if (wr1_en && wr1_addr == rd_addr[p]) e = wr1_data;
                if (wr0_en && wr0_addr == rd_addr[p]) e = wr0_data;
                expect_val(e, $sformatf("b2b_c%0d_p%0d_bypass", c, p));
                expect_val(base, $sformatf("b2b_c%0d_p%0d_nobypass", c, p));
            end
            #2;
            for (int p = 0; p < NUM_RD; p++) begin
                obs_q.push_back(rd_data_a[p]);
                obs_q.push_back(rd_data_b[p]);
            end
            if (wr1_en) begin
                if (wr1_addr[3]) mdl[0][wr1_addr] = wr1_data;
                else             mdl[bk][wr1_addr] = wr1_data;
            end
            if (wr0_en) begin
                if (wr0_addr[3]) mdl[0][wr0_addr] = wr0_data;
                else             mdl[bk][wr0_addr] = wr0_data;
            end
            tick();
        end
        clr_inputs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            o = 'x;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                $display("FAIL %s: observed 0x%08h expected 0x%08h", t, o, e);
                n_mis++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_bank();
        test_sr();
        test_mac();
        test_invalid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
